// File: rtl/rx_serial_4bits.sv
// Serial-in / parallel-out receiver for 4-bit frames, framed by a start strobe
// and clocked in bit by bit under an enable strobe.
module rx_serial_4bits #(
    parameter int unsigned LSB_FIRST = 1
) (
    input  logic       ck,
    input  logic       clr,
    input  logic       start,
    input  logic       en,
    input  logic       s_in,
    output logic [3:0] q,
    output logic       valid,
    output logic       busy,
    output logic       err
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RECV = 1'b1;

    logic [0:0] state_q, state_d;
    logic [3:0] sr_q, sr_d;
    logic [1:0] cnt_q, cnt_d;
    logic [3:0] q_q, q_d;
    logic       valid_q, valid_d;
    logic       busy_q, busy_d;
    logic       err_q, err_d;
    logic [3:0] sr_shift;

    assign sr_shift = (LSB_FIRST != 0) ? {s_in, sr_q[3:1]} : {sr_q[2:0], s_in};

    always_comb begin
        // NOTE: every next-state value gets a default first so no path leaves it unassigned (no latches).
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        valid_d = 1'b0;
        err_d   = err_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    sr_d    = 4'b0000;
                    cnt_d   = 2'd0;
                    state_d = RECV;
                end
            end
            RECV: begin
                if (start) begin
                    // A restart in the middle of a frame loses data, so it is flagged.
                    sr_d  = 4'b0000;
                    cnt_d = 2'd0;
                    if (cnt_q != 2'd0) begin
                        err_d = 1'b1;
                    end
                end else if (en) begin
                    sr_d  = sr_shift;
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        q_d     = sr_shift;
                        valid_d = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == RECV);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge ck) begin
        if (clr) begin
            state_q <= IDLE;
            sr_q    <= 4'b0000;
            cnt_q   <= 2'd0;
            q_q     <= 4'b0000;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    assign q     = q_q;
    assign valid = valid_q;
    assign busy  = busy_q;
    assign err   = err_q;

endmodule

// File: tb/tb_rx_serial_4bits.sv
// Scoreboard bench for rx_serial_4bits: directed frames push expected words,
// per-instance monitors pop and compare on every valid pulse.
module tb_rx_serial_4bits;

    typedef struct {
        logic [3:0] q;
        logic       err;
    } exp_t;

    logic       ck = 1'b0;
    logic       clr = 1'b1;
    logic       start = 1'b0, en = 1'b0, s_in = 1'b0;
    logic       start_b = 1'b0, en_b = 1'b0, s_in_b = 1'b0;
    logic [3:0] q, q_b;
    logic       valid, busy, err;
    logic       valid_b, busy_b, err_b;

    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;
    int valid_cyc[$];
    exp_t sb_a[$];
    logic [3:0] sb_b[$];

    rx_serial_4bits #(.LSB_FIRST(1)) dut_a (
        .ck(ck), .clr(clr), .start(start), .en(en), .s_in(s_in),
        .q(q), .valid(valid), .busy(busy), .err(err)
    );

    rx_serial_4bits #(.LSB_FIRST(0)) dut_b (
        .ck(ck), .clr(clr), .start(start_b), .en(en_b), .s_in(s_in_b),
        .q(q_b), .valid(valid_b), .busy(busy_b), .err(err_b)
    );

    always #5 ck = ~ck;

    always @(posedge ck) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end else begin
            n_pass++;
        end
    endtask

    // Monitors sample on the falling edge, well away from the capturing edge.
    always @(negedge ck) begin
        if (valid === 1'b1) begin
            valid_cyc.push_back(cyc);
            if (sb_a.size() == 0) begin
                check("a_unexpected_valid", {31'b0, valid}, 32'd0);
            end else begin
                exp_t e;
                e = sb_a.pop_front();
                check("a_q", {28'b0, q}, {28'b0, e.q});
                check("a_err_at_valid", {31'b0, err}, {31'b0, e.err});
            end
        end
    end

    always @(negedge ck) begin
        if (valid_b === 1'b1) begin
            if (sb_b.size() == 0) begin
                check("b_unexpected_valid", {31'b0, valid_b}, 32'd0);
            end else begin
                logic [3:0] e;
                e = sb_b.pop_front();
                check("b_q", {28'b0, q_b}, {28'b0, e});
            end
        end
    end

    task automatic drive(input logic st, input logic e, input logic b);
        start = st;
        en    = e;
        s_in  = b;
        @(posedge ck);
        #1;
        start = 1'b0;
        en    = 1'b0;
        s_in  = 1'b0;
    endtask

    task automatic drive_b(input logic st, input logic e, input logic b);
        start_b = st;
        en_b    = e;
        s_in_b  = b;
        @(posedge ck);
        #1;
        start_b = 1'b0;
        en_b    = 1'b0;
        s_in_b  = 1'b0;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        drive(1'b0, 1'b0, 1'b0);
        clr = 1'b0;
    endtask

    task automatic check_idle_reset(input string tag);
        check({tag, "_q"},     {28'b0, q},     32'd0);
        check({tag, "_busy"},  {31'b0, busy},  32'd0);
        check({tag, "_valid"}, {31'b0, valid}, 32'd0);
        check({tag, "_err"},   {31'b0, err},   32'd0);
    endtask

    // Sends four bits LSB first (w[0] first); last bit leaves valid high on return.
    task automatic send_lsb_first(input logic [3:0] w);
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, w[i]);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int base;
        #1;
        do_clr();
        do_clr();
        check_idle_reset("reset");
        check("reset_busy_b", {31'b0, busy_b}, 32'd0);

        // Basic frame 1,1,0,1 -> 4'b1011.
        drive(1'b1, 1'b0, 1'b0);
        check("frame1_busy", {31'b0, busy}, 32'd1);
        sb_a.push_back('{q: 4'b1011, err: 1'b0});
        send_lsb_first(4'b1011);
        check("frame1_busy_fall", {31'b0, busy}, 32'd0);
        check("frame1_valid", {31'b0, valid}, 32'd1);
        drive(1'b0, 1'b0, 1'b0);
        check("frame1_valid_one_cycle", {31'b0, valid}, 32'd0);
        check("frame1_q_held", {28'b0, q}, 32'hB);

        // Same frame with a 3-cycle gap between bits 2 and 3.
        drive(1'b1, 1'b0, 1'b0);
        sb_a.push_back('{q: 4'b1011, err: 1'b0});
        drive(1'b0, 1'b1, 1'b1);
        drive(1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 1'b1);
            check("gap_busy", {31'b0, busy}, 32'd1);
            check("gap_no_valid", {31'b0, valid}, 32'd0);
        end
        drive(1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 1'b1);
        drive(1'b0, 1'b0, 1'b0);

        // Restart with cnt=0 must not flag an error.
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b1);
        check("restart_cnt0_err", {31'b0, err}, 32'd0);
        check("restart_cnt0_busy", {31'b0, busy}, 32'd1);

        // Abort after 2 bits, then a full frame 0,0,1,0 -> 4'b0100 with err sticky.
        drive(1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 1'b0);
        check("partial_q_unchanged", {28'b0, q}, 32'hB);
        drive(1'b1, 1'b1, 1'b1);
        check("abort_err", {31'b0, err}, 32'd1);
        check("abort_busy", {31'b0, busy}, 32'd1);
        sb_a.push_back('{q: 4'b0100, err: 1'b1});
        send_lsb_first(4'b0100);
        repeat (3) drive(1'b0, 1'b0, 1'b0);
        check("err_sticky", {31'b0, err}, 32'd1);
        do_clr();
        check("clr_err", {31'b0, err}, 32'd0);
        check("clr_q", {28'b0, q}, 32'd0);

        // clr in the middle of a frame discards it; a stray 4th bit gives no valid.
        drive(1'b1, 1'b0, 1'b0);
        sb_a.push_back('{q: 4'b0111, err: 1'b0});
        drive(1'b0, 1'b1, 1'b1);
        drive(1'b0, 1'b1, 1'b1);
        drive(1'b0, 1'b1, 1'b1);
        void'(sb_a.pop_back());
        clr   = 1'b1;
        drive(1'b0, 1'b1, 1'b1);
        clr   = 1'b0;
        check_idle_reset("midclr");
        drive(1'b0, 1'b1, 1'b1);
        check("stray_bit_busy", {31'b0, busy}, 32'd0);
        repeat (2) drive(1'b0, 1'b0, 1'b0);
        check("stray_bit_q", {28'b0, q}, 32'd0);

        // Back-to-back frames, second start issued in the valid cycle.
        base = valid_cyc.size();
        drive(1'b1, 1'b0, 1'b0);
        sb_a.push_back('{q: 4'b0110, err: 1'b0});
        send_lsb_first(4'b0110);
        drive(1'b1, 1'b0, 1'b0);
        sb_a.push_back('{q: 4'b1001, err: 1'b0});
        send_lsb_first(4'b1001);
        repeat (2) drive(1'b0, 1'b0, 1'b0);
        check("b2b_pulse_count", valid_cyc.size(), base + 2);
        if (valid_cyc.size() >= base + 2) begin
            check("b2b_spacing", valid_cyc[base + 1] - valid_cyc[base], 32'd5);
        end
        check("b2b_err", {31'b0, err}, 32'd0);
        check("b2b_q_last", {28'b0, q}, 32'h9);

        // MSB-first instance: bits 1,0,0,0 -> 4'b1000.
        drive_b(1'b1, 1'b0, 1'b0);
        check("b_busy", {31'b0, busy_b}, 32'd1);
        sb_b.push_back(4'b1000);
        drive_b(1'b0, 1'b1, 1'b1);
        drive_b(1'b0, 1'b1, 1'b0);
        drive_b(1'b0, 1'b1, 1'b0);
        drive_b(1'b0, 1'b1, 1'b0);
        check("b_valid", {31'b0, valid_b}, 32'd1);
        repeat (2) drive_b(1'b0, 1'b0, 1'b0);
        check("b_q_held", {28'b0, q_b}, 32'h8);

        check("sb_a_drained", sb_a.size(), 32'd0);
        check("sb_b_drained", sb_b.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/rx_serial_4bits.md
RX_SERIAL_4BITS -- requirements
Module: rx_serial_4bits

Interface
REQ-001 Parameter: LSB_FIRST, default 1, bit order of the serial frame (1 = first received bit lands in q[0]; 0 = first received bit lands in q[3]).
REQ-002 ck  input  1  rising-edge clock; all state updates on this edge.
REQ-003 clr  input  1  reset, synchronous and active-high.
REQ-004 start  input  1  frame-begin strobe, sampled each ck edge.
REQ-005 en  input  1  bit-valid strobe; s_in is sampled only when en=1.
REQ-006 s_in  input  1  serial data bit.
REQ-007 q  output  4  last completely received word.
REQ-008 valid  output  1  one-cycle pulse marking a new word on q.
REQ-009 busy  output  1  high while a frame is being received.
REQ-010 err  output  1  sticky flag for a frame aborted by start.

Function
REQ-011 The block SHALL be the serial-in/parallel-out counterpart of the team's 4-bit parallel-load right-shift register, which emits LSB first.
REQ-012 The FSM SHALL have two states, IDLE and RECV, plus an internal 4-bit shift register sr and a 2-bit bit counter cnt.
REQ-013 In IDLE, start=1 SHALL set sr=0 and cnt=0 and move the FSM to RECV on that edge; en and s_in SHALL be ignored on that edge.
REQ-014 In IDLE with start=0, the FSM SHALL stay in IDLE and ignore en.
REQ-015 In RECV with en=1 and start=0, the shift SHALL depend on LSB_FIRST:
  - LSB_FIRST=1: sr <= {s_in, sr[3:1]} (right shift, new bit enters bit 3).
  - LSB_FIRST=0: sr <= {sr[2:0], s_in}.
  - In both cases cnt increments by 1.
REQ-016 In RECV with en=0 and start=0, sr, cnt and state SHALL hold; gaps of any length between bits are allowed.
REQ-017 On the edge that captures the 4th bit (cnt=3, en=1), the block SHALL:
  - load q with the shifted value including that bit;
  - drive valid=1 for exactly the following cycle;
  - wrap cnt to 0 and return the FSM to IDLE.
REQ-018 valid SHALL be 0 in every other cycle.
REQ-019 q SHALL change only on frame completion or clr, and SHALL be unaffected by partial frames.
REQ-020 busy SHALL equal 1 exactly when the FSM is in RECV, as a registered state decode with no combinational path from inputs.
REQ-021 In RECV, start=1 SHALL restart the frame (sr=0, cnt=0, stay in RECV) and discard the en/s_in of that edge.
REQ-022 If that restart occurs with cnt≠0, err SHALL be set to 1; a restart with cnt=0 SHALL NOT set err.
REQ-023 err SHALL remain 1 until clr.
REQ-024 start=1 in the cycle where valid=1 (FSM in IDLE) SHALL begin a new frame normally, with no error, so back-to-back frames lose no cycle.
REQ-025 q, valid, busy and err SHALL all be registered outputs.

Reset
REQ-026 clr=1 at a ck edge SHALL force: state=IDLE, sr=0, cnt=0, q=4'b0000, valid=0, busy=0, err=0.
REQ-027 clr SHALL dominate start and en on the same edge, including mid-frame; a partial frame is discarded and q is cleared.
REQ-028 With no clr ever applied, output values before the first clr are don't-care; benches SHALL apply clr first.

Verification
REQ-029 LSB_FIRST=1, start, then en=1 on 4 consecutive cycles with s_in=1,1,0,1 -> q=4'b1011 and valid=1 for one cycle after the 4th edge; busy falls in that same cycle.
REQ-030 Same frame with en low for 3 cycles between bits 2 and 3 -> identical q=4'b1011; busy stays high throughout the gap; no early valid.
REQ-031 After 2 bits, assert start -> err=1, cnt restarts; then send 0,0,1,0 -> q=4'b0100, valid pulses, err remains 1 until clr.
REQ-032 clr asserted after 3 bits of a frame -> next cycle q=0, busy=0, valid=0, err=0; a 4th en pulse with no new start produces no valid.
REQ-033 Back-to-back frames 4'b0110 then 4'b1001 with start in the valid cycle -> two valid pulses 5 cycles apart, q=4'b0110 then 4'b1001, err=0.
REQ-034 LSB_FIRST=0, bits 1,0,0,0 -> q=4'b1000.
